fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC loaded on reset.
REQ-002 The block SHALL have parameter PC_NEXT, default 3'd0, selecting sequential PC+4.
REQ-003 The block SHALL have parameter PC_JUMP, default 3'd1, selecting the J/JAL target.
REQ-004 The block SHALL have parameter PC_JR, default 3'd2, selecting the register jump target.
REQ-005 The block SHALL have parameter PC_BRANCH, default 3'd3, selecting the taken-branch target.
REQ-006 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  stage enable from the pipeline controller.
- pc_src  in  3  next-PC select, driven from the ID-stage instruction.
- branch_target  in  32  taken-branch address.
- jr_target  in  32  JR register value.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  fetch address.
- imem_ack  in  1  fetch data valid this cycle.
- imem_data  in  32  fetched instruction.
- inst_out  out  32  instruction register to ID.
- pc_out  out  32  PC+4 of inst_out.
- valid_out  out  1  inst_out holds a real instruction.
- fetch_busy  out  1  request outstanding and not acknowledged this cycle.

Function
REQ-007 The block SHALL hold registers pc, state (S_FETCH, S_BUF), buf_data, redir_pend and redir_pc.
REQ-008 In S_FETCH the block SHALL drive imem_req=1 and imem_addr=pc; in S_BUF, imem_req SHALL be 0.
REQ-009 fetch_busy SHALL equal (state==S_FETCH) & ~imem_ack, combinationally.
REQ-010 npc SHALL be selected as follows:
- pc_src==PC_JUMP: {pc_out[31:28], inst_out[25:0], 2'b00}.
- pc_src==PC_JR: jr_target.
- pc_src==PC_BRANCH: branch_target.
- any other code with redir_pend=1: redir_pc.
- otherwise: pc+4, modulo 2^32 (wraps from 32'hFFFF_FFFC to 0).
REQ-011 A "delivery" SHALL mean: inst_out<=instruction, pc_out<=pc+4, valid_out<=1, pc<=npc, redir_pend<=0.
REQ-012 S_FETCH with imem_ack=1 and en=1: the block SHALL deliver imem_data and stay in S_FETCH, giving one-cycle fetch-to-ID latency.
REQ-013 S_FETCH with imem_ack=1 and en=0: the block SHALL set buf_data<=imem_data, go to S_BUF, and hold pc and all outputs.
REQ-014 S_BUF with en=1: the block SHALL deliver buf_data and return to S_FETCH; with en=0 it SHALL hold everything.
REQ-015 S_FETCH with imem_ack=0 and en=1: the block SHALL set valid_out<=0 and inst_out<=0 (bubble) and hold pc.
- If pc_src is not PC_NEXT in that cycle, it SHALL also set redir_pend<=1 and redir_pc<=npc.
REQ-016 S_FETCH with imem_ack=0 and en=0: the block SHALL hold all state.
REQ-017 While en=0, pc_src SHALL be ignored and no redirect SHALL be captured.
REQ-018 A non-PC_NEXT pc_src with en=1 SHALL take priority over a pending redirect.
REQ-019 The instruction delivered in the same cycle as a redirect (branch delay slot) SHALL NOT be discarded.

Reset
REQ-020 While rst=1 the block SHALL set:
- pc=RESET_PC, state=S_FETCH, buf_data=0, redir_pend=0, redir_pc=0.
- inst_out=0, pc_out=0, valid_out=0.
- imem_req=0.
REQ-021 rst SHALL override en and imem_ack; an outstanding request SHALL be abandoned, and the first request after reset SHALL target RESET_PC.

Verification
REQ-022 Zero-wait memory, en=1, pc_src=0 after reset: addresses SHALL go 0,4,8,...; valid_out=1 from cycle 2 with pc_out=4,8,...
REQ-023 Ack for address 0x10 arrives while en=0 for 3 cycles: imem_req SHALL drop, and on the cycle after en rises, inst_out SHALL be the buffered word with pc_out=0x14.
REQ-024 pc_src=PC_BRANCH, branch_target=0x100, with ack the same cycle: the delay-slot instruction SHALL be delivered and the next imem_addr SHALL be 0x100.
REQ-025 pc_src=PC_JR, jr_target=0x200, during a 2-cycle ack wait: a bubble SHALL be inserted, and after the ack the next imem_addr SHALL be 0x200.
REQ-026 rst asserted mid-wait at pc=0x40: imem_req=0 and valid_out=0 during reset, and the first post-reset imem_addr SHALL be RESET_PC.
REQ-027 Start at pc=0xFFFF_FFFC with ack: the next address SHALL wrap to 0x0000_0000.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction memory request, buffers a word
// returned while ID is stalled, and remembers redirects that arrive during a wait.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [2:0]  PC_NEXT   = 3'd0,
  parameter logic [2:0]  PC_JUMP   = 3'd1,
  parameter logic [2:0]  PC_JR     = 3'd2,
  parameter logic [2:0]  PC_BRANCH = 3'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [2:0]  pc_src,
  input  logic [31:0] branch_target,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        valid_out,
  output logic        fetch_busy
);

  typedef enum logic {S_FETCH, S_BUF} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, buf_data, redir_pc;
  logic        redir_pend;
  logic [31:0] npc, pc_plus4, deliver_data;
  logic        deliver, bubble, capture;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: if (imem_ack && !en) state_nxt = S_BUF;
      S_BUF:   if (en)              state_nxt = S_FETCH;
      default: state_nxt = S_FETCH;
    endcase
  end

  // Request is masked during reset so the abandoned fetch never reaches memory.
  always_comb begin
    imem_req   = (state == S_FETCH) && !rst;
    imem_addr  = pc;
    fetch_busy = (state == S_FETCH) && !imem_ack;
  end

  assign pc_plus4 = pc + 32'd4;

  // Explicit pc_src beats a pending redirect; JUMP target uses the ID-stage instruction.
  always_comb begin
    if (pc_src == PC_JUMP)        npc = {pc_out[31:28], inst_out[25:0], 2'b00};
    else if (pc_src == PC_JR)     npc = jr_target;
    else if (pc_src == PC_BRANCH) npc = branch_target;
    else if (redir_pend)          npc = redir_pc;
    else                          npc = pc_plus4;
  end

  always_comb begin
    deliver      = en && ((state == S_BUF) || imem_ack);
    bubble       = en && (state == S_FETCH) && !imem_ack;
    capture      = !en && (state == S_FETCH) && imem_ack;
    deliver_data = (state == S_BUF) ? buf_data : imem_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      buf_data   <= '0;
      redir_pend <= 1'b0;
      redir_pc   <= '0;
      inst_out   <= '0;
      pc_out     <= '0;
      valid_out  <= 1'b0;
    end else begin
      if (deliver) begin
        inst_out   <= deliver_data;
        pc_out     <= pc_plus4;
        valid_out  <= 1'b1;
        pc         <= npc;
        redir_pend <= 1'b0;
      end else if (bubble) begin
        inst_out  <= '0;
        valid_out <= 1'b0;
        if (pc_src != PC_NEXT) begin
          redir_pend <= 1'b1;
          redir_pc   <= npc;
        end
      end
      if (capture) buf_data <= imem_data;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a scoreboard holds the expected (instruction, pc+4)
// pairs for each delivery, and fetch addresses are checked against known targets.
module tb_fetch_stage;

  localparam logic [2:0] NXT = 3'd0;
  localparam logic [2:0] JMP = 3'd1;
  localparam logic [2:0] JRG = 3'd2;
  localparam logic [2:0] BRN = 3'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [2:0]  pc_src = NXT;
  logic [31:0] branch_target = '0;
  logic [31:0] jr_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        fetch_busy;

  int checks = 0;
  int failures = 0;
  logic [63:0] sb[$];

  logic        en_q, rst_q;
  logic [63:0] exp_e;
  logic [31:0] prev_inst, prev_pc;
  logic        prev_valid;
  logic [31:0] w, jt;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .PC_NEXT  (NXT),
    .PC_JUMP  (JMP),
    .PC_JR    (JRG),
    .PC_BRANCH(BRN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .pc_src       (pc_src),
    .branch_target(branch_target),
    .jr_target    (jr_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_data    (imem_data),
    .inst_out     (inst_out),
    .pc_out       (pc_out),
    .valid_out    (valid_out),
    .fetch_busy   (fetch_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  // Memory returns a word derived from whatever address is presented.
  assign imem_data = word(imem_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Delivery happens exactly when en was high and the scoreboard holds an entry.
  always @(posedge clk) begin
    en_q  = en;
    rst_q = rst;
    #1;
    if (rst_q) begin
      check_eq("rst_valid", 32'(valid_out), 32'd0);
      check_eq("rst_inst", inst_out, 32'd0);
      check_eq("rst_pc", pc_out, 32'd0);
    end else if (en_q) begin
      check_eq("valid", 32'(valid_out), (sb.size() != 0) ? 32'd1 : 32'd0);
      if (sb.size() != 0) begin
        exp_e = sb.pop_front();
        check_eq("inst", inst_out, exp_e[63:32]);
        check_eq("pc_out", pc_out, exp_e[31:0]);
      end else begin
        check_eq("bubble_inst", inst_out, 32'd0);
      end
    end else begin
      check_eq("hold_valid", 32'(valid_out), 32'(prev_valid));
      check_eq("hold_inst", inst_out, prev_inst);
      check_eq("hold_pc", pc_out, prev_pc);
    end
    prev_valid = valid_out;
    prev_inst  = inst_out;
    prev_pc    = pc_out;
  end

  task automatic step(input logic e, input logic a, input logic [2:0] src,
                      input logic push, input logic [31:0] addr);
    en       = e;
    imem_ack = a;
    pc_src   = src;
    if (push) sb.push_back({word(addr), addr + 32'd4});
    @(negedge clk);
  endtask

  task automatic expect_fetch(input string tag, input logic [31:0] a);
    #1;
    check_eq({tag, "_req"}, 32'(imem_req), 32'd1);
    check_eq({tag, "_addr"}, imem_addr, a);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_req", 32'(imem_req), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      expect_fetch("seq", 32'(4 * i));
      step(1'b1, 1'b1, NXT, 1'b1, 32'(4 * i));
    end

    // Ack at 0x10 while stalled; pc_src is ignored while en is low.
    expect_fetch("buf", 32'h10);
    step(1'b0, 1'b1, NXT, 1'b0, '0);
    check_eq("buf_req", 32'(imem_req), 32'd0);
    branch_target = 32'h300;
    step(1'b0, 1'b0, BRN, 1'b0, '0);
    step(1'b0, 1'b0, BRN, 1'b0, '0);
    step(1'b1, 1'b0, NXT, 1'b1, 32'h10);
    expect_fetch("after_buf", 32'h14);

    branch_target = 32'h100;
    step(1'b1, 1'b1, BRN, 1'b1, 32'h14);
    expect_fetch("branch", 32'h100);
    step(1'b1, 1'b1, NXT, 1'b1, 32'h100);
    expect_fetch("seq2", 32'h104);

    jr_target = 32'h200;
    step(1'b1, 1'b0, JRG, 1'b0, '0);
    check_eq("busy", 32'(fetch_busy), 32'd1);
    step(1'b1, 1'b0, NXT, 1'b0, '0);
    step(1'b1, 1'b1, NXT, 1'b1, 32'h104);
    expect_fetch("jr", 32'h200);

    branch_target = 32'h300;
    step(1'b1, 1'b0, BRN, 1'b0, '0);
    jr_target = 32'h400;
    step(1'b1, 1'b1, JRG, 1'b1, 32'h200);
    expect_fetch("prio", 32'h400);

    step(1'b1, 1'b1, NXT, 1'b1, 32'h400);
    expect_fetch("seq3", 32'h404);
    w  = word(32'h400);
    jt = {4'h0, w[25:0], 2'b00};
    step(1'b1, 1'b1, JMP, 1'b1, 32'h404);
    expect_fetch("jump", jt);
    step(1'b1, 1'b1, NXT, 1'b1, jt);

    branch_target = 32'h40;
    step(1'b1, 1'b1, BRN, 1'b1, jt + 32'd4);
    expect_fetch("to40", 32'h40);
    step(1'b1, 1'b0, NXT, 1'b0, '0);

    // Reset during an outstanding fetch at 0x40.
    rst = 1'b1;
    en = 1'b1;
    imem_ack = 1'b1;
    #1;
    check_eq("rst_mid_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    check_eq("rst_mid_req2", 32'(imem_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
    imem_ack = 1'b0;
    expect_fetch("post_rst", 32'h0);

    branch_target = 32'hFFFF_FFFC;
    step(1'b1, 1'b1, BRN, 1'b1, 32'h0);
    expect_fetch("wrap_start", 32'hFFFF_FFFC);
    step(1'b1, 1'b1, NXT, 1'b1, 32'hFFFF_FFFC);
    expect_fetch("wrap", 32'h0);
    step(1'b1, 1'b1, NXT, 1'b1, 32'h0);
    step(1'b0, 1'b0, NXT, 1'b0, '0);

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
